// File: rtl/bpu_btb.sv
// Direct-mapped, tagged branch target buffer with per-entry saturating direction
// counters. Lookup is combinational off registered state; training is clocked.
module bpu_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            fetch_valid,
  input  logic            stall,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic            upd_is_jump,
  input  logic [XLEN-1:0] upd_target,
  input  logic            inval_all,
  output logic [31:0]     lookup_cnt,
  output logic [31:0]     hit_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));

  // Handshake: fetch_valid and upd_valid are pure qualifiers with no ready;
  // the BTB answers every lookup and accepts every update in the same cycle.

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];
  logic [ENTRIES-1:0] jmp_q;

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             hit;
  logic             u_hit;
  logic             unused_pc_lsbs;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[XLEN-1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[XLEN-1:IDX_W+2];
  assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

  // Masking with rst makes the fall-through prediction visible in the reset cycle.
  assign hit = fetch_valid & ~rst & valid_q[f_idx] & (tag_q[f_idx] == f_tag);
  assign u_hit = valid_q[u_idx] & (tag_q[u_idx] == u_tag);

  assign pred_taken  = hit & (jmp_q[f_idx] | cnt_q[f_idx][CNT_W-1]);
  assign pred_target = pred_taken ? target_q[f_idx] : fetch_pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      jmp_q      <= '0;
      lookup_cnt <= '0;
      hit_cnt    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      if (fetch_valid && !stall) begin
        lookup_cnt <= lookup_cnt + 32'd1;
        if (hit) hit_cnt <= hit_cnt + 32'd1;
      end

      if (inval_all) begin
        valid_q <= '0;
      end else if (upd_valid) begin
        if (u_hit) begin
          if (upd_taken) begin
            if (cnt_q[u_idx] != CNT_MAX) cnt_q[u_idx] <= cnt_q[u_idx] + CNT_ONE;
            target_q[u_idx] <= upd_target;
            jmp_q[u_idx]    <= upd_is_jump;
          end else if (cnt_q[u_idx] != CNT_ZERO) begin
            cnt_q[u_idx] <= cnt_q[u_idx] - CNT_ONE;
          end
        end else if (upd_taken) begin
          // Only taken outcomes allocate; a new entry starts weakly taken.
          valid_q[u_idx]  <= 1'b1;
          tag_q[u_idx]    <= u_tag;
          target_q[u_idx] <= upd_target;
          jmp_q[u_idx]    <= upd_is_jump;
          cnt_q[u_idx]    <= CNT_WEAK;
        end
      end
    end
  end

endmodule
